// File: rtl/seq_monitor.sv
// Sequence monitor for an upstream 3-bit counter: acquires lock after LOCK_CNT legal
// transitions, then flags, counts and latches successor mismatches.
module seq_monitor #(
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             load_en,
    input  logic [2:0]       data_in,
    input  logic             err_clr,
    output logic             locked,
    output logic             err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       loop_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAcq    = 2'b01,
        StLocked = 2'b10
    } state_e;

    localparam logic [2:0]       LockCnt = 3'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ErrMax  = '1;

    state_e           state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    logic [2:0]       match_q, match_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             sticky_q, sticky_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic [7:0]       loop_q, loop_d;
    logic [2:0]       match_inc;
    logic             is_succ;

    function automatic logic [2:0] succ(input logic [2:0] p);
        logic [2:0] s;
        case (p)
            3'b000:  s = 3'b110;
            3'b001:  s = 3'b110;
            3'b010:  s = 3'b111;
            3'b011:  s = 3'b000;
            3'b100:  s = 3'b111;
            3'b101:  s = 3'b010;
            3'b110:  s = 3'b100;
            default: s = 3'b011;
        endcase
        return s;
    endfunction

    assign match_inc = match_q + 3'd1;
    assign is_succ   = (data_in == succ(prev_q));

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        match_d  = match_q;
        err_d    = 1'b0;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        loop_d   = loop_q;

        // Clear first so a same-edge locked mismatch still counts as the first new error.
        if (err_clr) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end

        if (load_en) begin
            state_d = StIdle;
            match_d = 3'd0;
        end else if (en) begin
            prev_d = data_in;
            case (state_q)
                StIdle: begin
                    match_d = 3'd0;
                    state_d = StAcq;
                end
                StAcq: begin
                    if (!is_succ) begin
                        match_d = 3'd0;
                    end else if (match_inc == LockCnt) begin
                        match_d = 3'd0;
                        state_d = StLocked;
                    end else begin
                        match_d = match_inc;
                    end
                end
                StLocked: begin
                    if (is_succ) begin
                        if (data_in == 3'b000) begin
                            loop_d = loop_q + 8'd1;
                        end
                    end else begin
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                        cnt_d    = (cnt_d == ErrMax) ? cnt_d : cnt_d + 1'b1;
                        match_d  = 3'd0;
                        state_d  = StAcq;
                    end
                end
                default: begin
                    match_d = 3'd0;
                    state_d = StIdle;
                end
            endcase
        end

        locked_d = (state_d == StLocked);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= StIdle;
            prev_q   <= 3'd0;
            match_q  <= 3'd0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            loop_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            match_q  <= match_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            loop_q   <= loop_d;
        end
    end

    assign locked     = locked_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign err_cnt    = cnt_q;
    assign loop_cnt   = loop_q;
    assign state      = state_q;

endmodule
